// File: rtl/md_pos_pkg.sv
// Shared types and constants for the position-cell read path.
// Record layout is {posz, posy, posx}, 32 bits each.
package md_pos_pkg;

    localparam int unsigned POS_WIDTH      = 32;
    localparam int unsigned DATA_WIDTH     = 3 * POS_WIDTH;
    localparam int unsigned RAM_RD_LATENCY = 2;

    typedef struct packed {
        logic [POS_WIDTH-1:0] posz;
        logic [POS_WIDTH-1:0] posy;
        logic [POS_WIDTH-1:0] posx;
    } pos_rec_t;

    typedef enum logic [2:0] {
        StIdle,
        StRdCnt,
        StWaitCnt,
        StStream,
        StDrain,
        StFin
    } stream_state_e;

endpackage

// File: rtl/pos_skid_fifo.sv
// Small first-word-fall-through FIFO with an occupancy output.
// The head entry is always visible on rdata_o while valid_o is high.
module pos_skid_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       wr_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       rd_i,
    output logic                       valid_o,
    output logic [WIDTH-1:0]           rdata_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CntW = $clog2(DEPTH + 1);
    localparam logic [PtrW-1:0] LastPtr = PtrW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PtrW-1:0]  wr_ptr_q;
    logic [PtrW-1:0]  rd_ptr_q;
    logic [CntW-1:0]  count_q;
    logic [CntW-1:0]  count_d;
    logic             full;
    logic             do_wr;
    logic             do_rd;

    assign full  = (count_q == CntW'(DEPTH));
    assign do_rd = rd_i && (count_q != '0);
    // A write into a full FIFO is only accepted if the head leaves in the same cycle.
    assign do_wr = wr_i && (!full || do_rd);

    always_comb begin
        count_d = count_q;
        if (do_wr && !do_rd) begin
            count_d = count_q + CntW'(1);
        end else if (!do_wr && do_rd) begin
            count_d = count_q - CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_wr) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + PtrW'(1);
            end
            if (do_rd) begin
                rd_ptr_q <= (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign valid_o = (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    no_overflow_a: assert property (@(posedge clk_i) disable iff (!rst_ni)
        !(wr_i && full && !do_rd))
        else $error("pos_skid_fifo: write into full FIFO");

endmodule

// File: rtl/pos_cell_streamer.sv
// Reads the particle count of one position cell, then streams every record
// downstream through a credit-controlled skid FIFO so RAM reads are never lost.
module pos_cell_streamer
    import md_pos_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = md_pos_pkg::DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH   = 8,
    parameter int unsigned PARTICLE_NUM = 220,
    parameter int unsigned FIFO_DEPTH   = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  start_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  cnt_err_o,
    output logic [ADDR_WIDTH-1:0] mem_address_o,
    output logic                  mem_rden_o,
    output logic                  mem_wren_o,
    input  logic [DATA_WIDTH-1:0] mem_q_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [DATA_WIDTH-1:0] out_data_o,
    output logic [ADDR_WIDTH-1:0] out_pid_o,
    output logic                  out_last_o,
    output logic [ADDR_WIDTH-1:0] cell_count_o
);

    localparam int unsigned FifoW    = DATA_WIDTH + ADDR_WIDTH + 1;
    localparam int unsigned FifoCntW = $clog2(FIFO_DEPTH + 1);
    localparam int unsigned OccW     = $clog2(FIFO_DEPTH + 4);
    localparam logic [ADDR_WIDTH-1:0] MaxCount = ADDR_WIDTH'(PARTICLE_NUM - 1);

    stream_state_e state_q, state_d;
    logic [1:0]            wait_q, wait_d;
    logic [ADDR_WIDTH-1:0] next_addr_q, next_addr_d;
    logic [ADDR_WIDTH-1:0] cell_count_q, cell_count_d;
    logic                  cnt_err_q, cnt_err_d;
    logic                  rden_q, rden_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [1:0]            ret_vld_q;
    logic [ADDR_WIDTH-1:0] ret_pid_q [2];
    logic [1:0]            ret_last_q;

    logic                  rd_data;
    logic                  fifo_valid;
    logic [FifoW-1:0]      fifo_head;
    logic [FifoCntW-1:0]   fifo_count;
    logic                  pop;
    logic                  head_last;
    logic [OccW-1:0]       occ;
    logic                  credit_ok;
    logic [ADDR_WIDTH-1:0] raw_count;
    logic [ADDR_WIDTH-1:0] clamped_count;

    // Address 0 holds the count, so only non-zero reads carry records.
    assign rd_data   = rden_q && (addr_q != '0);
    assign pop       = fifo_valid && out_ready_i;
    assign head_last = fifo_head[FifoW-1];

    // Slots already promised: buffered entries plus every read still in flight,
    // minus the entry leaving this cycle.
    assign occ = OccW'(fifo_count) + OccW'(rd_data) + OccW'(ret_vld_q[0])
               + OccW'(ret_vld_q[1]) - OccW'(pop);
    assign credit_ok = (occ < OccW'(FIFO_DEPTH));

    assign raw_count     = mem_q_i[ADDR_WIDTH-1:0];
    assign clamped_count = (raw_count > MaxCount) ? MaxCount : raw_count;

    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        next_addr_d  = next_addr_q;
        cell_count_d = cell_count_q;
        cnt_err_d    = cnt_err_q;
        rden_d       = 1'b0;
        addr_d       = addr_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    state_d   = StRdCnt;
                    rden_d    = 1'b1;
                    addr_d    = '0;
                    cnt_err_d = 1'b0;
                end
            end
            StRdCnt: begin
                state_d = StWaitCnt;
                wait_d  = '0;
            end
            StWaitCnt: begin
                if (wait_q == 2'(RAM_RD_LATENCY - 1)) begin
                    cell_count_d = clamped_count;
                    cnt_err_d    = (raw_count > MaxCount);
                    if (clamped_count == '0) begin
                        state_d = StFin;
                    end else begin
                        rden_d      = 1'b1;
                        addr_d      = ADDR_WIDTH'(1);
                        next_addr_d = ADDR_WIDTH'(2);
                        state_d     = (clamped_count == ADDR_WIDTH'(1)) ? StDrain : StStream;
                    end
                end else begin
                    wait_d = wait_q + 2'd1;
                end
            end
            StStream: begin
                if (credit_ok) begin
                    rden_d = 1'b1;
                    addr_d = next_addr_q;
                    if (next_addr_q == cell_count_q) begin
                        state_d = StDrain;
                    end else begin
                        next_addr_d = next_addr_q + ADDR_WIDTH'(1);
                    end
                end
            end
            StDrain: begin
                if (pop && head_last && !rd_data && (ret_vld_q == '0)) begin
                    state_d = StFin;
                end
            end
            StFin: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            wait_q       <= '0;
            next_addr_q  <= '0;
            cell_count_q <= '0;
            cnt_err_q    <= 1'b0;
            rden_q       <= 1'b0;
            addr_q       <= '0;
        end else begin
            state_q      <= state_d;
            wait_q       <= wait_d;
            next_addr_q  <= next_addr_d;
            cell_count_q <= cell_count_d;
            cnt_err_q    <= cnt_err_d;
            rden_q       <= rden_d;
            addr_q       <= addr_d;
        end
    end

    // Tags travel alongside the RAM pipeline so they meet mem_q_i in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ret_vld_q    <= '0;
            ret_last_q   <= '0;
            ret_pid_q[0] <= '0;
            ret_pid_q[1] <= '0;
        end else begin
            ret_vld_q[0]  <= rd_data;
            ret_pid_q[0]  <= addr_q;
            ret_last_q[0] <= (addr_q == cell_count_q);
            ret_vld_q[1]  <= ret_vld_q[0];
            ret_pid_q[1]  <= ret_pid_q[0];
            ret_last_q[1] <= ret_last_q[0];
        end
    end

    pos_skid_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FifoW)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .wr_i    (ret_vld_q[1]),
        .wdata_i ({ret_last_q[1], ret_pid_q[1], mem_q_i}),
        .rd_i    (pop),
        .valid_o (fifo_valid),
        .rdata_o (fifo_head),
        .count_o (fifo_count)
    );

    assign busy_o        = (state_q != StIdle);
    assign done_o        = (state_q == StFin);
    assign cnt_err_o     = cnt_err_q;
    assign mem_address_o = addr_q;
    assign mem_rden_o    = rden_q;
    assign mem_wren_o    = 1'b0;
    assign out_valid_o   = fifo_valid;
    assign out_data_o    = fifo_head[DATA_WIDTH-1:0];
    assign out_pid_o     = fifo_head[DATA_WIDTH +: ADDR_WIDTH];
    assign out_last_o    = head_last;
    assign cell_count_o  = cell_count_q;

endmodule
